// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC unit and its IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC       = 4;
    localparam logic [63:0] BUBBLE_INSTR = '0;

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, load beats hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bubble_i,
    input  logic               load_i,
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pcplus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pcplus4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pcplus4_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (bubble_i) begin
            instr_q   <= BUBBLE_INSTR[INSTR_W-1:0];
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= valid_i;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, BOOT/RUN/HALTED sequencer and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: word-aligns redirect targets and flags the next valid instruction.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCSrcW,
    input  logic [ADDR_W-1:0]  ResultW,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               Halt,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [ADDR_W-1:0]  PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCPlus4D,
    output logic               ValidD,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic               MisalignD,
`endif
    output logic               Busy
);

    localparam logic [3:0] BOOT_CNT_INIT = 4'(BOOT_CYCLES - 1);

    fetch_state_t      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pcf_q, pcf_d;
    logic [ADDR_W-1:0] pcf_plus4, redirect_pc;
    logic              ifid_bubble, ifid_load, ifid_valid;
    logic              redirect_take;

    assign pcf_plus4     = pcf_q + ADDR_W'(PC_INC);
    assign redirect_take = PCSrcW && (state_q != BOOT);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc = {ResultW[ADDR_W-1:2], 2'b00};
`else
    assign redirect_pc = ResultW;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            cnt_q   <= BOOT_CNT_INIT;
            pcf_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcf_q   <= pcf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pcf_d       = pcf_q;
        ifid_bubble = 1'b0;
        ifid_load   = 1'b0;
        ifid_valid  = 1'b1;
        case (state_q)
            BOOT: begin
                ifid_bubble = 1'b1;
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RUN: begin
                if (PCSrcW)       pcf_d   = redirect_pc;
                else if (Halt)    state_d = HALTED;
                else if (!StallF) pcf_d   = pcf_plus4;
                if (FlushD || PCSrcW) begin
                    ifid_bubble = 1'b1;
                end else if (!StallD) begin
                    ifid_load  = 1'b1;
                    ifid_valid = !Halt;
                end
            end
            HALTED: begin
                if (PCSrcW) pcf_d   = redirect_pc;
                if (!Halt)  state_d = RUN;
                // The held PCF is re-fetched in RUN, so nothing is lost here.
                ifid_bubble = FlushD || !StallD;
            end
            default: state_d = BOOT;
        endcase
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble_i  (ifid_bubble),
        .load_i    (ifid_load),
        .valid_i   (ifid_valid),
        .instr_i   (InstrF),
        .pcplus4_i (pcf_plus4),
        .instr_o   (InstrD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic sticky_q, sticky_d, misalign_q, misalign_d;

    always_comb begin
        sticky_d   = sticky_q;
        misalign_d = misalign_q;
        if (ifid_bubble)    misalign_d = 1'b0;
        else if (ifid_load) misalign_d = ifid_valid && sticky_q;
        if (redirect_take)                      sticky_d = |ResultW[1:0];
        else if (ifid_load && ifid_valid)       sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            misalign_q <= misalign_d;
        end
    end

    assign MisalignD = misalign_q;
`endif

    assign PCF  = pcf_q;
    assign Busy = (state_q != RUN);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected IF/ID contents are queued as fetches are stimulated.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCSrcW = 1'b0;
    logic [31:0] ResultW = '0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        Halt = 1'b0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        Busy;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        MisalignD;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign InstrF = mem_word(PCF);

    fetch_pc_unit #(
        .ADDR_W      (32),
        .INSTR_W     (32),
        .RESET_PC    (32'h0000_0000),
        .BOOT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCSrcW   (PCSrcW),
        .ResultW  (ResultW),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .Halt     (Halt),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
`ifdef FETCH_ALIGN_CHECK_EN
        .MisalignD(MisalignD),
`endif
        .Busy     (Busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        e.instr = mem_word(a);
        e.pc4   = a + 32'd4;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (PCF !== 32'h0) begin
            n_err++; $display("FAIL reset_pcf: got %h want 00000000", PCF);
        end
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D} !== 65'h0) begin
            n_err++; $display("FAIL reset_ifid: got v=%0b i=%h p=%h want all zero", ValidD, InstrD, PCPlus4D);
        end
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_err++; $display("FAIL reset_busy: got %0b want 1", Busy);
        end
    endtask

    task automatic test_boot_sequential();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({PCF, ValidD, Busy} !== {32'h0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL boot1: got pcf=%h v=%0b busy=%0b want 0/0/1", PCF, ValidD, Busy);
        end
        step();
        n_cmp++;
        if ({PCF, ValidD, Busy} !== {32'h0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL boot2: got pcf=%h v=%0b busy=%0b want 0/0/0", PCF, ValidD, Busy);
        end
        for (int i = 0; i < 4; i++) begin
            push_fetch(32'(4 * i));
            step();
            e = sb.pop_front();
            n_cmp++;
            if ({PCF, ValidD, InstrD, PCPlus4D} !== {32'(4 * (i + 1)), 1'b1, e.instr, e.pc4}) begin
                n_err++;
                $display("FAIL seq_%0d: got pcf=%h v=%0b i=%h p=%h want pcf=%h v=1 i=%h p=%h",
                         i, PCF, ValidD, InstrD, PCPlus4D, 32'(4 * (i + 1)), e.instr, e.pc4);
            end
        end
    endtask

    task automatic test_redirect();
        PCSrcW = 1'b1; ResultW = 32'h40;
        step();
        PCSrcW = 1'b0;
        n_cmp++;
        if ({PCF, ValidD} !== {32'h40, 1'b0}) begin
            n_err++; $display("FAIL redirect_pcf: got pcf=%h v=%0b want 00000040/0", PCF, ValidD);
        end
        push_fetch(32'h40);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b1, e.instr, e.pc4, 32'h44}) begin
            n_err++; $display("FAIL redirect_ifid: got v=%0b i=%h p=%h pcf=%h want v=1 i=%h p=%h pcf=00000044",
                              ValidD, InstrD, PCPlus4D, PCF, e.instr, e.pc4);
        end
    endtask

    task automatic test_stall();
        PCSrcW = 1'b1; ResultW = 32'h04;
        step();
        PCSrcW = 1'b0;
        push_fetch(32'h04);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b1, e.instr, e.pc4, 32'h08}) begin
            n_err++; $display("FAIL stall_pre: got v=%0b i=%h p=%h pcf=%h want v=1 i=%h p=%h pcf=00000008",
                              ValidD, InstrD, PCPlus4D, PCF, e.instr, e.pc4);
        end
        StallF = 1'b1; StallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({PCF, ValidD, InstrD, PCPlus4D} !== {32'h08, 1'b1, mem_word(32'h04), 32'h08}) begin
                n_err++; $display("FAIL stall_hold_%0d: got pcf=%h v=%0b i=%h p=%h want pcf=00000008 v=1 i=%h p=00000008",
                                  k, PCF, ValidD, InstrD, PCPlus4D, mem_word(32'h04));
            end
        end
        StallF = 1'b0; StallD = 1'b0;
        push_fetch(32'h08);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b1, e.instr, e.pc4, 32'h0C}) begin
            n_err++; $display("FAIL stall_resume: got v=%0b i=%h p=%h pcf=%h want v=1 i=%h p=%h pcf=0000000c",
                              ValidD, InstrD, PCPlus4D, PCF, e.instr, e.pc4);
        end
    endtask

    task automatic test_collision();
        StallF = 1'b1; PCSrcW = 1'b1; ResultW = 32'h100;
        step();
        PCSrcW = 1'b0; StallF = 1'b0;
        n_cmp++;
        if ({PCF, ValidD} !== {32'h100, 1'b0}) begin
            n_err++; $display("FAIL stallf_vs_redirect: got pcf=%h v=%0b want 00000100/0", PCF, ValidD);
        end
        push_fetch(32'h100);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D} !== {1'b1, e.instr, e.pc4}) begin
            n_err++; $display("FAIL collide_fetch: got v=%0b i=%h p=%h want v=1 i=%h p=%h",
                              ValidD, InstrD, PCPlus4D, e.instr, e.pc4);
        end
        StallD = 1'b1; FlushD = 1'b1; StallF = 1'b1;
        step();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b0, 32'h0, 32'h0, 32'h104}) begin
            n_err++; $display("FAIL flush_vs_stalld: got v=%0b i=%h p=%h pcf=%h want v=0 i=0 p=0 pcf=00000104",
                              ValidD, InstrD, PCPlus4D, PCF);
        end
        StallD = 1'b0; FlushD = 1'b0; StallF = 1'b0;
        push_fetch(32'h104);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D} !== {1'b1, e.instr, e.pc4}) begin
            n_err++; $display("FAIL after_flush: got v=%0b i=%h p=%h want v=1 i=%h p=%h",
                              ValidD, InstrD, PCPlus4D, e.instr, e.pc4);
        end
    endtask

    task automatic test_wrap();
        PCSrcW = 1'b1; ResultW = 32'hFFFF_FFFC;
        step();
        PCSrcW = 1'b0;
        push_fetch(32'hFFFF_FFFC);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({PCF, ValidD, InstrD, PCPlus4D} !== {32'h0, 1'b1, e.instr, e.pc4}) begin
            n_err++; $display("FAIL wrap: got pcf=%h v=%0b i=%h p=%h want pcf=00000000 v=1 i=%h p=%h",
                              PCF, ValidD, InstrD, PCPlus4D, e.instr, e.pc4);
        end
        push_fetch(32'h0);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({PCF, ValidD, InstrD, PCPlus4D} !== {32'h4, 1'b1, e.instr, e.pc4}) begin
            n_err++; $display("FAIL wrap_next: got pcf=%h v=%0b i=%h p=%h want pcf=00000004 v=1 i=%h p=%h",
                              PCF, ValidD, InstrD, PCPlus4D, e.instr, e.pc4);
        end
    endtask

    task automatic test_halt();
        PCSrcW = 1'b1; ResultW = 32'h20;
        step();
        PCSrcW = 1'b0; Halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({PCF, Busy, ValidD} !== {32'h20, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL halt_hold_%0d: got pcf=%h busy=%0b v=%0b want 00000020/1/0",
                                  k, PCF, Busy, ValidD);
            end
        end
        Halt = 1'b0;
        step();
        n_cmp++;
        if ({PCF, Busy, ValidD} !== {32'h20, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL halt_exit: got pcf=%h busy=%0b v=%0b want 00000020/0/0", PCF, Busy, ValidD);
        end
        push_fetch(32'h20);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b1, e.instr, e.pc4, 32'h24}) begin
            n_err++; $display("FAIL halt_resume: got v=%0b i=%h p=%h pcf=%h want v=1 i=%h p=%h pcf=00000024",
                              ValidD, InstrD, PCPlus4D, PCF, e.instr, e.pc4);
        end
    endtask

    task automatic test_halt_redirect();
        Halt = 1'b1;
        step();
        PCSrcW = 1'b1; ResultW = 32'h80;
        step();
        PCSrcW = 1'b0;
        n_cmp++;
        if ({PCF, Busy, ValidD} !== {32'h80, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL halted_redirect: got pcf=%h busy=%0b v=%0b want 00000080/1/0", PCF, Busy, ValidD);
        end
        Halt = 1'b0;
        step();
        push_fetch(32'h80);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF, Busy} !== {1'b1, e.instr, e.pc4, 32'h84, 1'b0}) begin
            n_err++; $display("FAIL halted_redirect_fetch: got v=%0b i=%h p=%h pcf=%h busy=%0b want v=1 i=%h p=%h pcf=00000084 busy=0",
                              ValidD, InstrD, PCPlus4D, PCF, Busy, e.instr, e.pc4);
        end
    endtask

    task automatic test_mid_reset();
        PCSrcW = 1'b1; ResultW = 32'h200;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({PCF, ValidD, InstrD, PCPlus4D, Busy} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
            n_err++; $display("FAIL async_reset: got pcf=%h v=%0b i=%h p=%h busy=%0b want zeros busy=1",
                              PCF, ValidD, InstrD, PCPlus4D, Busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; ResultW = 32'h300;
        step();
        PCSrcW = 1'b0;
        n_cmp++;
        if ({PCF, Busy} !== {32'h0, 1'b1}) begin
            n_err++; $display("FAIL boot_ignores_redirect: got pcf=%h busy=%0b want 00000000/1", PCF, Busy);
        end
        step();
        push_fetch(32'h0);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, PCPlus4D, PCF} !== {1'b1, e.instr, e.pc4, 32'h4}) begin
            n_err++; $display("FAIL reboot_fetch: got v=%0b i=%h p=%h pcf=%h want v=1 i=%h p=%h pcf=00000004",
                              ValidD, InstrD, PCPlus4D, PCF, e.instr, e.pc4);
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        PCSrcW = 1'b1; ResultW = 32'h42;
        step();
        PCSrcW = 1'b0;
        n_cmp++;
        if (PCF !== 32'h40) begin
            n_err++; $display("FAIL misalign_pcf: got %h want 00000040", PCF);
        end
        push_fetch(32'h40);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, MisalignD} !== {1'b1, e.instr, 1'b1}) begin
            n_err++; $display("FAIL misalign_flag: got v=%0b i=%h m=%0b want v=1 i=%h m=1", ValidD, InstrD, MisalignD, e.instr);
        end
        push_fetch(32'h44);
        step();
        e = sb.pop_front();
        n_cmp++;
        if ({ValidD, InstrD, MisalignD} !== {1'b1, e.instr, 1'b0}) begin
            n_err++; $display("FAIL misalign_clear: got v=%0b i=%h m=%0b want v=1 i=%h m=0", ValidD, InstrD, MisalignD, e.instr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_boot_sequential();
        test_redirect();
        test_stall();
        test_collision();
        test_wrap();
        test_halt();
        test_halt_redirect();
        test_mid_reset();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
